// File: rtl/pe_pkg.sv
// Purpose: shared PE definitions (FSM state encoding, default widths, counter sizing helper).
// Latency: n/a, declarations only.
// Backpressure: n/a, declarations only.
//
// Contents:
//   pe_state_e   - three-state handshake FSM encoding used by the serial PE cells
//   PE_DATA_W    - default operand width of the PE datapath
//   pe_cnt_w()   - bit-counter width for a given operand width (never below 1)
package pe_pkg;

  typedef enum logic [1:0] {
    PE_IDLE = 2'd0,
    PE_RUN  = 2'd1,
    PE_DONE = 2'd2
  } pe_state_e;

  localparam int PE_DATA_W = 8;

  // A counter must hold indices 0..width-1; a 1-bit counter is the floor.
  function automatic int pe_cnt_w(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Purpose: combinational 1-bit full subtractor cell, d = a - b - bin.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake.
//
// Ports:
//   i_a    - minuend bit
//   i_b    - subtrahend bit
//   i_bin  - borrow-in
//   o_d    - difference bit
//   o_bout - borrow-out
module full_subtractor_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  // Borrow when a=0,b=1, or when a==b and a borrow was already pending.
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Purpose: LSB-first bit-serial subtractor, {o_bout,o_diff} = i_din1 - i_din2 - i_bin.
// Latency: o_out_valid rises WIDTH edges after the accept edge; minimum initiation interval WIDTH+2.
// Backpressure: result is held in DONE while i_out_ready=0; o_in_ready stays low until it is taken.
//
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   i_in_valid / o_in_ready   - operand handshake (i_din1, i_din2, i_bin sampled on accept)
//   i_din1, i_din2, i_bin     - minuend, subtrahend, borrow-in (unsigned)
//   o_out_valid / i_out_ready - result handshake
//   o_diff, o_bout            - difference mod 2^WIDTH and borrow-out
module bit_serial_subtractor
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_din1,
  input  logic [WIDTH-1:0] i_din2,
  input  logic             i_bin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int               CNT_W    = pe_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  pe_state_e        r_state;
  pe_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             r_in_ready;
  logic             r_out_valid;

  logic w_accept;
  logic w_release;
  logic w_last;
  logic w_d;
  logic w_br_nxt;

  // r_in_ready is low in the first IDLE cycle after reset, so it gates accept as well.
  assign w_accept  = (r_state == PE_IDLE) && r_in_ready && i_in_valid;
  assign w_release = (r_state == PE_DONE) && r_out_valid && i_out_ready;
  assign w_last    = (r_state == PE_RUN) && (r_cnt == CNT_LAST);

  full_subtractor_bit u_fs (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_br_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PE_IDLE: if (w_accept)  w_state_nxt = PE_RUN;
      PE_RUN:  if (w_last)    w_state_nxt = PE_DONE;
      PE_DONE: if (w_release) w_state_nxt = PE_IDLE;
      default:                w_state_nxt = PE_IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state, so both outputs
  // come straight from flops and in_ready is low in the cycle a result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PE_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == PE_IDLE);
      r_out_valid <= (w_state_nxt == PE_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= i_din1;
      r_b   <= i_din2;
      r_br  <= i_bin;
      r_cnt <= '0;
    end else if (r_state == PE_RUN) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_br   <= w_br_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
      // Difference bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      if (w_last) begin
        r_bout <= w_br_nxt;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_diff      = r_diff;
  assign o_bout      = r_bout;

endmodule
